// File: rtl/tcp_session_handler_dbg_pkg.sv
// Shared debug-path types for the tcp_session_handler monitors.
// Holds the per-channel stall FSM encoding and the default block threshold.
package tcp_session_handler_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } stall_state_t;

    localparam int DEFAULT_STALL_THRESH = 1024;

endpackage

// File: rtl/tcp_session_handler_axis_stall_chan.sv
// One AXIS channel's stall tracker: counts consecutive stall cycles and
// reports BLOCKED once the stall has persisted for STALL_THRESH cycles.
module tcp_session_handler_axis_stall_chan
    import tcp_session_handler_dbg_pkg::*;
#(
    parameter int STALL_THRESH = DEFAULT_STALL_THRESH,
    parameter int CNT_W        = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic cond,
    output logic blocked,
    output logic enter_blocked
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_THRESH - 1);

    stall_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cond) begin
                        if (STALL_THRESH == 1) begin
                            state_d = BLOCKED;
                            cnt_d   = CNT_LAST;
                        end else begin
                            state_d = COUNT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (!cond) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        // Counter parks at its last value so it can never wrap.
                        state_d = BLOCKED;
                        cnt_d   = CNT_LAST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLOCKED: begin
                    if (!cond) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign blocked       = (state_q == BLOCKED);
    assign enter_blocked = (state_d == BLOCKED) && (state_q != BLOCKED);

endmodule

// File: rtl/tcp_session_handler_axis_stall_detector.sv
// Per-channel AXIS stall detector feeding the session-handler deadlock monitor,
// with sticky stall flags and first-blocked-channel capture for debug.
module tcp_session_handler_axis_stall_detector
    import tcp_session_handler_dbg_pkg::*;
#(
    parameter int                NUM_CH       = 5,
    parameter logic [NUM_CH-1:0] IN_MASK      = 5'b00011,
    parameter int                STALL_THRESH = DEFAULT_STALL_THRESH,
    parameter int                CNT_W        = 16,
    parameter int                IDX_W        = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              inst_idle,
    input  logic [NUM_CH-1:0] axis_tvalid,
    input  logic [NUM_CH-1:0] axis_tready,
    input  logic              clear,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic [NUM_CH-1:0] stall_sticky,
    output logic              first_stall_vld,
    output logic [IDX_W-1:0]  first_stall_ch
);

    logic [NUM_CH-1:0] cond;
    logic [NUM_CH-1:0] enter;

    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic              vld_q, vld_d;
    logic [IDX_W-1:0]  ch_q, ch_d;
    logic [IDX_W-1:0]  first_idx;
    logic              any_enter;

    // Input channels only count as stalled while the kernel is actually running.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            if (IN_MASK[gi]) begin : g_in
                assign cond[gi] = axis_tready[gi] & ~axis_tvalid[gi] & ~inst_idle;
            end else begin : g_out
                assign cond[gi] = axis_tvalid[gi] & ~axis_tready[gi];
            end

            tcp_session_handler_axis_stall_chan #(
                .STALL_THRESH (STALL_THRESH),
                .CNT_W        (CNT_W)
            ) u_chan (
                .clock         (clock),
                .reset         (reset),
                .enable        (enable),
                .cond          (cond[gi]),
                .blocked       (axis_block_sigs[gi]),
                .enter_blocked (enter[gi])
            );
        end
    endgenerate

    always_comb begin
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (enter[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

    assign any_enter = |enter;

    // A clear coinciding with a fresh BLOCKED entry keeps only that entry.
    always_comb begin
        sticky_d = clear ? enter : (sticky_q | enter);
        vld_d    = clear ? any_enter : (vld_q | any_enter);
        ch_d     = ch_q;
        if (any_enter && (clear || !vld_q)) begin
            ch_d = first_idx;
        end else if (clear) begin
            ch_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sticky_q <= '0;
            vld_q    <= 1'b0;
            ch_q     <= '0;
        end else begin
            sticky_q <= sticky_d;
            vld_q    <= vld_d;
            ch_q     <= ch_d;
        end
    end

    assign stall_sticky    = sticky_q;
    assign first_stall_vld = vld_q;
    assign first_stall_ch  = ch_q;

endmodule

// File: tb/tb_tcp_session_handler_axis_stall_detector.sv
// Directed scoreboard bench: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_tcp_session_handler_axis_stall_detector;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       enable    = 1'b1;
    logic       inst_idle = 1'b0;
    logic       clear     = 1'b0;
    logic [4:0] tvalid    = '0;
    logic [4:0] tready    = '0;
    logic [4:0] block_sigs;
    logic [4:0] sticky;
    logic       first_vld;
    logic [2:0] first_ch;

    tcp_session_handler_axis_stall_detector dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .inst_idle       (inst_idle),
        .axis_tvalid     (tvalid),
        .axis_tready     (tready),
        .clear           (clear),
        .axis_block_sigs (block_sigs),
        .stall_sticky    (sticky),
        .first_stall_vld (first_vld),
        .first_stall_ch  (first_ch)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        string      name;
        logic [4:0] blk;
        logic [4:0] stk;
        logic       vld;
        logic [2:0] ch;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            n_cmp++;
            if (mon_e.cyc != cyc || block_sigs !== mon_e.blk || sticky !== mon_e.stk ||
                first_vld !== mon_e.vld || first_ch !== mon_e.ch) begin
                n_bad++;
                $display("FAIL %s cyc=%0d due=%0d got blk=%b stk=%b vld=%b ch=%0d want blk=%b stk=%b vld=%b ch=%0d",
                         mon_e.name, cyc, mon_e.cyc, block_sigs, sticky, first_vld, first_ch,
                         mon_e.blk, mon_e.stk, mon_e.vld, mon_e.ch);
            end else begin
                $display("ok   %s cyc=%0d blk=%b stk=%b vld=%b ch=%0d",
                         mon_e.name, cyc, block_sigs, sticky, first_vld, first_ch);
            end
        end
    end

    task automatic exp_at(input int dc, input string nm, input logic [4:0] b,
                          input logic [4:0] s, input logic v, input logic [2:0] c);
        exp_t e;
        e.cyc  = cyc + dc;
        e.name = nm;
        e.blk  = b;
        e.stk  = s;
        e.vld  = v;
        e.ch   = c;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_clear(input string nm);
        clear = 1'b1;
        exp_at(1, nm, 5'b00000, 5'b00000, 1'b0, 3'd0);
        step(1);
        clear = 1'b0;
        step(1);
    endtask

    initial begin
        // Reset state
        step(2);
        exp_at(1, "reset", 5'b00000, 5'b00000, 1'b0, 3'd0);
        step(1);
        reset = 1'b0;

        // ch0 is an input channel (IN_MASK=00011): stall = tready & ~tvalid while running
        tready[0] = 1'b1;
        exp_at(1023, "ch0_pre",   5'b00000, 5'b00000, 1'b0, 3'd0);
        exp_at(1024, "ch0_block", 5'b00001, 5'b00001, 1'b1, 3'd0);
        exp_at(1029, "ch0_hold",  5'b00001, 5'b00001, 1'b1, 3'd0);
        step(1030);
        tready[0] = 1'b0;
        exp_at(1, "ch0_release", 5'b00000, 5'b00001, 1'b1, 3'd0);
        step(2);
        pulse_clear("clear1");

        // Output ch2 stall with a single transfer at cycle 1000
        tvalid[2] = 1'b1;
        exp_at(1024, "xfer_noblock", 5'b00000, 5'b00000, 1'b0, 3'd0);
        exp_at(2023, "xfer_pre",     5'b00000, 5'b00000, 1'b0, 3'd0);
        exp_at(2024, "xfer_block",   5'b00100, 5'b00100, 1'b1, 3'd2);
        step(999);
        tready[2] = 1'b1;
        step(1);
        tready[2] = 1'b0;
        step(1030);
        tvalid[2] = 1'b0;
        exp_at(1, "xfer_release", 5'b00000, 5'b00100, 1'b1, 3'd2);
        step(2);
        pulse_clear("clear2");

        // Input ch1 masked by inst_idle, then unmasked
        inst_idle = 1'b1;
        tready[1] = 1'b1;
        exp_at(2000, "idle_mask", 5'b00000, 5'b00000, 1'b0, 3'd0);
        step(2000);
        inst_idle = 1'b0;
        exp_at(1023, "ch1_pre",   5'b00000, 5'b00000, 1'b0, 3'd0);
        exp_at(1024, "ch1_block", 5'b00010, 5'b00010, 1'b1, 3'd1);
        step(1026);
        tready[1] = 1'b0;
        exp_at(1, "ch1_release", 5'b00000, 5'b00010, 1'b1, 3'd1);
        step(2);

        // ch3 and ch2 block on the same edge while clear is pulsed on that edge
        tvalid[3:2] = 2'b11;
        exp_at(1023, "pair_pre",   5'b00000, 5'b00010, 1'b1, 3'd1);
        exp_at(1024, "pair_clear", 5'b01100, 5'b01100, 1'b1, 3'd2);
        step(1023);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        exp_at(1, "pair_hold", 5'b01100, 5'b01100, 1'b1, 3'd2);
        step(2);
        tvalid[3:2] = 2'b00;
        exp_at(1, "pair_release", 5'b00000, 5'b01100, 1'b1, 3'd2);
        step(2);
        pulse_clear("clear3");

        // enable dropped while blocked, then re-enabled
        tready[0] = 1'b1;
        exp_at(1024, "en_block", 5'b00001, 5'b00001, 1'b1, 3'd0);
        step(1025);
        enable = 1'b0;
        exp_at(1, "en_off", 5'b00000, 5'b00001, 1'b1, 3'd0);
        step(5);
        enable = 1'b1;
        exp_at(1023, "reen_pre",   5'b00000, 5'b00001, 1'b1, 3'd0);
        exp_at(1024, "reen_block", 5'b00001, 5'b00001, 1'b1, 3'd0);
        step(1025);
        tready[0] = 1'b0;
        exp_at(1, "reen_release", 5'b00000, 5'b00001, 1'b1, 3'd0);
        step(2);

        // Reset at count 500 with the stall held throughout
        tready[0] = 1'b1;
        step(500);
        reset = 1'b1;
        exp_at(1, "rst_mid", 5'b00000, 5'b00000, 1'b0, 3'd0);
        step(1);
        reset = 1'b0;
        exp_at(1023, "rst_pre",   5'b00000, 5'b00000, 1'b0, 3'd0);
        exp_at(1024, "rst_block", 5'b00001, 5'b00001, 1'b1, 3'd0);
        step(1025);
        tready[0] = 1'b0;
        step(2);

        for (int k = 0; k < 20 && sbq.size() > 0; k++) step(1);
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", sbq.size());
            n_bad += sbq.size();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
